ut_datapath: RTL and testbench
==============================

Name: ut_datapath

Overview:
Processing-unit datapath driven by the accumulator CPU control unit. It consumes the control strobes (sel_UAL, load_accu, load_R1, load_carry, clear_carry, enable_mem, w_mem, adr). It returns the memory read data and the carry flag to the control unit. It also contains the program/data RAM and a boot loader that fills the RAM from a byte stream while boot is high.

Parameters:
DATA_W  8  datapath and memory word width
ADDR_W  6  address width; RAM depth = 2**ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; 0 freezes every register, the RAM and the loader
boot  in  1  1 = boot load mode, control strobes ignored
boot_valid  in  1  boot_data valid this cycle
boot_data  in  DATA_W  byte to load
boot_done  out  1  all RAM words loaded; held while boot=1
sel_UAL  in  3  ALU operation select
load_accu  in  1  accu <= ALU result
load_R1  in  1  R1 <= mem_data
load_carry  in  1  carry <= ALU carry-out
clear_carry  in  1  carry <= 0
enable_mem  in  1  memory access enable
w_mem  in  1  with enable_mem: mem[adr] <= accu
adr  in  ADDR_W  memory address
mem_data  out  DATA_W  read data mem[adr]; goes to control unit data_in
carry  out  1  carry flag register
accu_out  out  DATA_W  accumulator value (debug/observation)

Behaviour:
- Reset (rst_n=0, async): accu=0, R1=0, carry=0, boot_ptr=0, loader state IDLE, boot_done=0. RAM contents are not reset.
- All register updates happen on the rising clk edge, and only when ce=1.
- mem_data = mem[adr], combinational read. It is valid irrespective of enable_mem and is 0-latency.
- ALU (combinational, A=accu, B=R1, 9-bit internal):
  - 000 A, cout 0
  - 001 ~(A|B), cout 0
  - 010 A+B, cout = bit 8
  - 011 B, cout 0
  - 100 A&B, cout 0
  - 101 A|B, cout 0
  - 110 A^B, cout 0
  - 111 A-B mod 2**DATA_W, cout = 1 if A>=B (no borrow)
- Run mode (boot=0):
  - load_R1: R1 <= mem[adr] (the pre-edge value).
  - load_accu: accu <= ALU result, computed from pre-edge A and B.
  - load_R1 and load_accu in the same cycle: the ALU uses the old R1.
  - load_carry: carry <= cout.
  - clear_carry has priority over load_carry.
  - enable_mem & w_mem: mem[adr] <= pre-edge accu. A same-cycle load_accu does not affect the written value.
  - w_mem without enable_mem: no write.
- Loader FSM:
  - IDLE --(boot=1)--> LOAD.
  - In LOAD, each cycle with boot_valid=1: mem[boot_ptr] <= boot_data, then boot_ptr+1 (wraps mod depth).
  - On the write to address depth-1, go to DONE and set boot_done=1.
  - In DONE, further boot_valid is ignored (no overwrite).
  - Any state --(boot=0)--> IDLE: boot_ptr=0, boot_done=0.
- While boot=1, all control strobes are ignored: no accu/R1/carry/RAM update from the run path. mem_data still reflects mem[adr].
- Boot dropped mid-load: the partially loaded RAM is kept. The next boot restarts at address 0.
- Reset mid-load: same as boot drop, plus the registers clear.
- ce=0 during LOAD: boot_valid is ignored for that cycle and the pointer does not advance.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> accu=0, R1=0, carry=0, boot_done=0 immediately.
- Boot load:
  - Stimulus: boot=1, then 64 boot_valid bytes 0x00..0x3F with gaps of boot_valid=0.
  - Required: boot_done rises on the cycle after the 64th byte, and a 65th byte (0xFF) is ignored.
  - After boot=0: boot_done=0, and adr=5 gives mem_data=0x05.
- Add with carry:
  - Stimulus: mem[2]=0xF0 and mem[3]=0x20. load_R1 at adr=2; sel_UAL=011 with load_accu; load_R1 at adr=3; sel_UAL=010 with load_accu and load_carry.
  - Required: accu=0x10, carry=1.
  - Then clear_carry together with load_carry -> carry=0.
- NOR/SUB:
  - accu=0x0F, R1=0x03, sel=001 with load_accu -> accu=0xF0.
  - Then accu=0x02, R1=0x03, sel=111 with load_accu and load_carry -> accu=0xFF, carry=0.
- Store ordering:
  - Stimulus: accu=0x55. In one cycle: enable_mem=1, w_mem=1, adr=9, load_accu with sel=011 (R1=0xAA).
  - Required: mem[9]=0x55, accu=0xAA.
  - Stimulus: w_mem=1 with enable_mem=0 at adr=10 -> mem[10] unchanged.
- Isolation:
  - boot=1 with load_accu/w_mem asserted -> no register or RAM change from the run path.
  - ce=0 for 3 cycles with strobes and boot_valid -> all state frozen, boot_ptr unchanged.

Source files
------------

// File: rtl/ut_datapath.sv
// ---------------------------------------------------------------------------
// ut_datapath
//
// Purpose:
//   Datapath of the accumulator CPU.
//   - It holds the accumulator (accu), the operand register R1 and the carry
//     flag.
//   - A combinational ALU takes A = accu and B = R1.
//   - The program/data RAM has a combinational read port.
//   - A boot loader fills the RAM from a byte stream while boot is high.
//   - The control unit drives the strobes and gets back mem_data and carry.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset (RAM contents survive)
//   ce           in   clock enable; 0 freezes registers, RAM and loader
//   boot         in   1 = boot load mode; run-path strobes are ignored
//   boot_valid   in   boot_data valid this cycle
//   boot_data    in   byte to load at the current boot pointer
//   boot_done    out  every RAM word loaded; held while boot stays high
//   sel_UAL      in   ALU operation select (3 bits)
//   load_accu    in   accu <= ALU result
//   load_R1      in   R1 <= mem[adr]
//   load_carry   in   carry <= ALU carry-out
//   clear_carry  in   carry <= 0 (wins over load_carry)
//   enable_mem   in   memory access enable
//   w_mem        in   with enable_mem: mem[adr] <= accu
//   adr          in   memory address
//   mem_data     out  mem[adr], combinational
//   carry        out  carry flag register
//   accu_out     out  accumulator value
// ---------------------------------------------------------------------------
module ut_datapath #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic              boot,
   input  logic              boot_valid,
   input  logic [DATA_W-1:0] boot_data,
   output logic              boot_done,
   input  logic [2:0]        sel_UAL,
   input  logic              load_accu,
   input  logic              load_R1,
   input  logic              load_carry,
   input  logic              clear_carry,
   input  logic              enable_mem,
   input  logic              w_mem,
   input  logic [ADDR_W-1:0] adr,
   output logic [DATA_W-1:0] mem_data,
   output logic              carry,
   output logic [DATA_W-1:0] accu_out
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LOAD = 2'd1,
      LD_DONE = 2'd2
   } ld_state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] accu_q,     accu_d;
   logic [DATA_W-1:0] r1_q,       r1_d;
   logic              carry_q,    carry_d;
   ld_state_t         state_q,    state_d;
   logic [ADDR_W-1:0] boot_ptr_q, boot_ptr_d;

   // The RAM is not reset. Its read port is asynchronous, so mem_data is
   // valid in the same cycle as adr.
   logic [DATA_W-1:0] mem_q [0:DEPTH-1];

   // ------------------------------------------------------------------
   // ALU
   // The ALU works on 9 bits so that bit DATA_W carries the add carry.
   // For subtract, the same bit is the borrow, and cout is its inverse
   // (cout = 1 when A >= B).
   // ------------------------------------------------------------------
   logic [DATA_W:0]   a_ext, b_ext;
   logic [DATA_W:0]   sum_ext, diff_ext;
   logic [DATA_W-1:0] alu_res;
   logic              alu_cout;

   assign a_ext    = {1'b0, accu_q};
   assign b_ext    = {1'b0, r1_q};
   assign sum_ext  = a_ext + b_ext;
   assign diff_ext = a_ext - b_ext;

   always_comb begin
      alu_res  = accu_q;
      alu_cout = 1'b0;
      case (sel_UAL)
         3'b000: alu_res = accu_q;
         3'b001: alu_res = ~(accu_q | r1_q);
         3'b010: begin
            alu_res  = sum_ext[DATA_W-1:0];
            alu_cout = sum_ext[DATA_W];
         end
         3'b011: alu_res = r1_q;
         3'b100: alu_res = accu_q & r1_q;
         3'b101: alu_res = accu_q | r1_q;
         3'b110: alu_res = accu_q ^ r1_q;
         3'b111: begin
            alu_res  = diff_ext[DATA_W-1:0];
            alu_cout = ~diff_ext[DATA_W];
         end
         default: begin
            alu_res  = accu_q;
            alu_cout = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Run path: active only when boot is low and ce is high.
   // Every source below is a pre-edge value, so load_R1 and load_accu in
   // the same cycle make the ALU see the old R1.
   // ------------------------------------------------------------------
   logic run_en;
   logic run_we;

   assign run_en = ce & ~boot;
   assign run_we = run_en & enable_mem & w_mem;

   always_comb begin
      accu_d  = accu_q;
      r1_d    = r1_q;
      carry_d = carry_q;
      if (run_en) begin
         if (load_R1) begin
            r1_d = mem_q[adr];
         end
         if (load_accu) begin
            accu_d = alu_res;
         end
         if (clear_carry) begin
            carry_d = 1'b0;
         end else if (load_carry) begin
            carry_d = alu_cout;
         end
      end
   end

   // ------------------------------------------------------------------
   // Boot loader FSM
   // Dropping boot sends every state back to IDLE and rewinds the pointer.
   // RAM contents loaded so far are kept.
   // ------------------------------------------------------------------
   logic ld_we;

   always_comb begin
      state_d    = state_q;
      boot_ptr_d = boot_ptr_q;
      ld_we      = 1'b0;
      if (ce) begin
         if (!boot) begin
            state_d    = LD_IDLE;
            boot_ptr_d = '0;
         end else begin
            case (state_q)
               LD_IDLE: state_d = LD_LOAD;
               LD_LOAD: begin
                  if (boot_valid) begin
                     ld_we      = 1'b1;
                     boot_ptr_d = boot_ptr_q + ADDR_W'(1);
                     if (boot_ptr_q == {ADDR_W{1'b1}}) begin
                        state_d = LD_DONE;
                     end
                  end
               end
               // Once loaded, further bytes must not overwrite address 0
               // after the pointer wraps.
               LD_DONE: state_d = LD_DONE;
               default: state_d = LD_IDLE;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // RAM write port
   // The loader and the run path never write in the same cycle, because
   // boot gates both of them.
   // ------------------------------------------------------------------
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;

   always_comb begin
      mem_we = ld_we | run_we;
      mem_wa = adr;
      mem_wd = accu_q;
      if (ld_we) begin
         mem_wa = boot_ptr_q;
         mem_wd = boot_data;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_wa] <= mem_wd;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accu_q     <= '0;
         r1_q       <= '0;
         carry_q    <= 1'b0;
         state_q    <= LD_IDLE;
         boot_ptr_q <= '0;
      end else begin
         accu_q     <= accu_d;
         r1_q       <= r1_d;
         carry_q    <= carry_d;
         state_q    <= state_d;
         boot_ptr_q <= boot_ptr_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mem_data  = mem_q[adr];
   assign carry     = carry_q;
   assign accu_out  = accu_q;
   assign boot_done = (state_q == LD_DONE);

endmodule

// File: tb/tb_ut_datapath.sv
module tb_ut_datapath;

   logic       clk;
   logic       rst_n;
   logic       ce;
   logic       boot;
   logic       boot_valid;
   logic [7:0] boot_data;
   logic       boot_done;
   logic [2:0] sel_UAL;
   logic       load_accu;
   logic       load_R1;
   logic       load_carry;
   logic       clear_carry;
   logic       enable_mem;
   logic       w_mem;
   logic [5:0] adr;
   logic [7:0] mem_data;
   logic       carry;
   logic [7:0] accu_out;

   ut_datapath #(.DATA_W(8), .ADDR_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ce          (ce),
      .boot        (boot),
      .boot_valid  (boot_valid),
      .boot_data   (boot_data),
      .boot_done   (boot_done),
      .sel_UAL     (sel_UAL),
      .load_accu   (load_accu),
      .load_R1     (load_R1),
      .load_carry  (load_carry),
      .clear_carry (clear_carry),
      .enable_mem  (enable_mem),
      .w_mem       (w_mem),
      .adr         (adr),
      .mem_data    (mem_data),
      .carry       (carry),
      .accu_out    (accu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed signal selectors
   localparam int SIG_ACCU = 0;
   localparam int SIG_CARRY = 1;
   localparam int SIG_MEM = 2;
   localparam int SIG_DONE = 3;

   typedef struct {
      string      name;
      int         sig;
      logic [7:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   // Monitor: at each falling edge, pop every pending expectation and
   // compare it with the live DUT output.
   exp_t       mon_e;
   logic [7:0] mon_act;
   always begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         case (mon_e.sig)
            SIG_ACCU:  mon_act = accu_out;
            SIG_CARRY: mon_act = {7'd0, carry};
            SIG_MEM:   mon_act = mem_data;
            default:   mon_act = {7'd0, boot_done};
         endcase
         checks++;
         if (mon_act !== mon_e.val) begin
            failures++;
            $display("FAIL %s actual=0x%02h expected=0x%02h", mon_e.name, mon_act, mon_e.val);
         end else begin
            $display("ok   %s actual=0x%02h expected=0x%02h", mon_e.name, mon_act, mon_e.val);
         end
      end
   end

   task automatic expect_sig(input string name, input int sig, input logic [7:0] val);
      exp_t e;
      e.name = name;
      e.sig  = sig;
      e.val  = val;
      sb_q.push_back(e);
   endtask

   task automatic flush();
      @(negedge clk);
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      boot_valid  = 1'b0;
      sel_UAL     = 3'b000;
      load_accu   = 1'b0;
      load_R1     = 1'b0;
      load_carry  = 1'b0;
      clear_carry = 1'b0;
      enable_mem  = 1'b0;
      w_mem       = 1'b0;
   endtask

   task automatic chk_mem(input string name, input logic [5:0] a, input logic [7:0] val);
      adr = a;
      expect_sig(name, SIG_MEM, val);
      flush();
   endtask

   // Drive a single run-path operation for one clock.
   task automatic op(input logic [2:0] sel, input logic la, input logic lr,
                     input logic lc, input logic cc, input logic en,
                     input logic wm, input logic [5:0] a);
      sel_UAL     = sel;
      load_accu   = la;
      load_R1     = lr;
      load_carry  = lc;
      clear_carry = cc;
      enable_mem  = en;
      w_mem       = wm;
      adr         = a;
      step();
      clr();
   endtask

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rst_n     = 1'b0;
      ce        = 1'b1;
      boot      = 1'b0;
      boot_data = 8'h00;
      adr       = 6'd0;
      clr();
      step();
      step();
      rst_n = 1'b1;
      expect_sig("reset_accu", SIG_ACCU, 8'h00);
      expect_sig("reset_carry", SIG_CARRY, 8'h00);
      expect_sig("reset_boot_done", SIG_DONE, 8'h00);
      flush();

      // ---------------- Boot load: bytes 0x00..0x3F with gaps
      boot = 1'b1;
      step();
      for (int i = 0; i < 64; i++) begin
         boot_valid = 1'b1;
         boot_data  = 8'(i);
         step();
         boot_valid = 1'b0;
         if (i == 62) begin
            expect_sig("boot_done_before_last", SIG_DONE, 8'h00);
            flush();
         end
         if (i % 4 == 1) step();
      end
      expect_sig("boot_done_rise", SIG_DONE, 8'h01);
      flush();
      chk_mem("boot_read_during_boot", 6'd5, 8'h05);
      boot_valid = 1'b1;
      boot_data  = 8'hFF;
      step();
      clr();
      chk_mem("boot_65th_ignored", 6'd0, 8'h00);
      expect_sig("boot_done_held", SIG_DONE, 8'h01);
      flush();

      // ---------------- Isolation: strobes ignored while boot=1
      op(3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd7);
      op(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd7);
      expect_sig("iso_accu", SIG_ACCU, 8'h00);
      expect_sig("iso_carry", SIG_CARRY, 8'h00);
      flush();
      chk_mem("iso_mem7", 6'd7, 8'h07);
      boot = 1'b0;
      step();
      expect_sig("boot_done_clear", SIG_DONE, 8'h00);
      flush();
      chk_mem("boot_mem5", 6'd5, 8'h05);
      op(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      expect_sig("iso_r1", SIG_ACCU, 8'h00);
      flush();

      // ---------------- Add with carry
      op(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd15);   // R1=0F
      op(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);    // accu=F0
      expect_sig("setup_nor_f0", SIG_ACCU, 8'hF0);
      flush();
      op(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd2);    // mem[2]=F0
      op(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd32);   // R1=20
      op(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);    // accu=20
      op(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd3);    // mem[3]=20
      chk_mem("store_mem2", 6'd2, 8'hF0);
      chk_mem("store_mem3", 6'd3, 8'h20);
      op(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2);    // R1=F0
      op(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);    // accu=F0
      op(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3);    // R1=20
      op(3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);    // F0+20
      expect_sig("add_accu", SIG_ACCU, 8'h10);
      expect_sig("add_carry", SIG_CARRY, 8'h01);
      flush();
      op(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);    // R1=00
      op(3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);    // cout would be 1
      expect_sig("clear_prio_carry", SIG_CARRY, 8'h00);
      expect_sig("clear_prio_accu", SIG_ACCU, 8'h10);
      flush();
      // 10-00 sets carry only if the ALU sees the old R1 (00), not 20
      op(3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3);
      expect_sig("old_r1_carry", SIG_CARRY, 8'h01);
      flush();

      // ---------------- Asynchronous reset mid-cycle
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      expect_sig("async_rst_accu", SIG_ACCU, 8'h00);
      expect_sig("async_rst_carry", SIG_CARRY, 8'h00);
      expect_sig("async_rst_done", SIG_DONE, 8'h00);
      flush();
      rst_n = 1'b1;
      chk_mem("rst_ram_kept", 6'd2, 8'hF0);
      op(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      expect_sig("rst_r1", SIG_ACCU, 8'h00);
      flush();

      // ---------------- NOR / SUB
      op(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd7);    // R1=07
      op(3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd4);    // accu=07 R1=04
      op(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);    // accu=03
      op(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd40);   // mem[40]=03
      op(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd15);   // R1=0F
      op(3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd40);   // accu=0F R1=03
      expect_sig("nor_setup_accu", SIG_ACCU, 8'h0F);
      flush();
      op(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);    // 0F>=03
      expect_sig("sub_noborrow_carry", SIG_CARRY, 8'h01);
      flush();
      op(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      expect_sig("nor_accu", SIG_ACCU, 8'hF0);
      flush();
      op(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd6);    // R1=06
      op(3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd4);    // accu=06 R1=04
      op(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd40);   // accu=02 R1=03
      op(3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);    // 02-03
      expect_sig("sub_accu", SIG_ACCU, 8'hFF);
      expect_sig("sub_borrow_carry", SIG_CARRY, 8'h00);
      flush();

      // ---------------- Store ordering
      op(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h2A);   // R1=2A
      op(3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h2B);   // accu=2A R1=2B
      op(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);    // accu=55
      op(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd20);   // mem[20]=55
      op(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd20);   // R1=55
      op(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);    // accu=AA
      op(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd21);   // mem[21]=AA
      op(3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd21);   // accu=55 R1=AA
      expect_sig("store_setup_accu", SIG_ACCU, 8'h55);
      flush();
      op(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd9);
      expect_sig("store_same_cycle_accu", SIG_ACCU, 8'hAA);
      flush();
      chk_mem("store_preedge_mem9", 6'd9, 8'h55);
      op(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd10);
      chk_mem("wmem_no_enable", 6'd10, 8'h0A);

      // ---------------- AND / OR
      op(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd15);   // R1=0F
      op(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);    // AA&0F
      expect_sig("and_accu", SIG_ACCU, 8'h0A);
      flush();
      op(3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);    // 0A|0F
      expect_sig("or_accu", SIG_ACCU, 8'h0F);
      flush();

      // ---------------- ce=0 during LOAD and during run
      boot = 1'b1;
      step();
      boot_valid = 1'b1;
      boot_data  = 8'h77;
      step();                                      // mem[0]=77, ptr=1
      ce        = 1'b0;
      boot_data = 8'h99;
      repeat (3) step();
      ce        = 1'b1;
      boot_data = 8'h88;
      step();                                      // mem[1]=88
      clr();
      chk_mem("ce_ptr_held_mem1", 6'd1, 8'h88);
      chk_mem("ce_no_write_mem2", 6'd2, 8'hF0);
      expect_sig("ce_boot_done", SIG_DONE, 8'h00);
      flush();
      boot = 1'b0;
      step();
      chk_mem("reboot_from_zero", 6'd0, 8'h77);
      ce          = 1'b0;
      sel_UAL     = 3'b111;
      load_accu   = 1'b1;
      load_R1     = 1'b1;
      load_carry  = 1'b1;
      enable_mem  = 1'b1;
      w_mem       = 1'b1;
      adr         = 6'd11;
      repeat (3) step();
      clr();
      ce = 1'b1;
      expect_sig("ce_frozen_accu", SIG_ACCU, 8'h0F);
      expect_sig("ce_frozen_carry", SIG_CARRY, 8'h00);
      flush();
      chk_mem("ce_frozen_mem11", 6'd11, 8'h0B);
      op(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      expect_sig("ce_frozen_r1", SIG_ACCU, 8'h0F);
      flush();

      flush();
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
